// File: rtl/regfile_wb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb
// Purpose  : Write-back end of the datapath. A 32 x W-bit MIPS register file
//            with a pending-write scoreboard. Decode issues destinations
//            (marking them busy) and reads two operands combinationally. The
//            write-back port retires results and clears busy bits. A
//            same-cycle write-back is bypassed onto the read ports.
// Ports    : clk, reset           - clock, synchronous active-high reset
//            rs_addr/rs_data/rs_busy - read port A (combinational)
//            rt_addr/rt_data/rt_busy - read port B (combinational)
//            issue_valid/issue_dest/issue_ready - destination ownership
//            wb_valid/wb_dest/wb_data           - result retirement
//            pending_count - registered count of busy registers
//            wb_orphan     - registered pulse: write-back to a non-busy reg
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb #(
    parameter int W    = 32,
    parameter int NREG = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [4:0]   rs_addr,
    input  logic [4:0]   rt_addr,
    output logic [W-1:0] rs_data,
    output logic [W-1:0] rt_data,
    output logic         rs_busy,
    output logic         rt_busy,
    input  logic         issue_valid,
    input  logic [4:0]   issue_dest,
    output logic         issue_ready,
    input  logic         wb_valid,
    input  logic [4:0]   wb_dest,
    input  logic [W-1:0] wb_data,
    output logic [5:0]   pending_count,
    output logic         wb_orphan
);

    localparam int c_AW = 5;

    logic [W-1:0]    r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [5:0]      r_count;
    logic            r_orphan;

    logic            w_wb_en;
    logic            w_issue_ready;
    logic            w_issue_acc;
    logic            w_inc;
    logic            w_dec;
    logic [NREG-1:0] w_busy_next;

    // Register 0 is filtered out here so nothing downstream has to care.
    assign w_wb_en = wb_valid & (wb_dest != '0);

    // A write-back retiring the very register being issued frees it in the
    // same cycle, so WAW stalls only when the owner is still outstanding.
    assign w_issue_ready = ~r_busy[issue_dest] | (wb_valid & (wb_dest == issue_dest));
    assign w_issue_acc   = issue_valid & w_issue_ready & (issue_dest != '0);

    // Count moves only on real bit transitions: an issue onto an already set
    // bit (same-cycle retire + re-issue) leaves the count unchanged.
    assign w_inc = w_issue_acc & ~r_busy[issue_dest];
    assign w_dec = w_wb_en & r_busy[wb_dest] &
                   ~(w_issue_acc & (issue_dest == wb_dest));

    always_comb begin
        w_busy_next = r_busy;
        if (w_wb_en)
            w_busy_next[wb_dest] = 1'b0;
        // Issue applied last so it wins over a same-register retire.
        if (w_issue_acc)
            w_busy_next[issue_dest] = 1'b1;
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
            r_busy   <= '0;
            r_count  <= '0;
            r_orphan <= 1'b0;
        end else begin
            if (w_wb_en)
                r_regs[wb_dest] <= wb_data;
            r_busy   <= w_busy_next;
            r_count  <= r_count + 6'(w_inc) - 6'(w_dec);
            r_orphan <= w_wb_en & ~r_busy[wb_dest];
        end
    end

    // Read port with bypass. The bypassed register reads not-busy unless an
    // issue to it is accepted in the same cycle, in which case it stays owned.
    function automatic logic [W:0] read_port(input logic [c_AW-1:0] addr);
        logic [W-1:0] data;
        logic         busy;
        if (addr == '0) begin
            data = '0;
            busy = 1'b0;
        end else if (w_wb_en && (wb_dest == addr)) begin
            data = wb_data;
            busy = w_issue_acc && (issue_dest == addr);
        end else begin
            data = r_regs[addr];
            busy = r_busy[addr];
        end
        return {busy, data};
    endfunction

    assign {rs_busy, rs_data} = read_port(rs_addr);
    assign {rt_busy, rt_data} = read_port(rt_addr);

    assign issue_ready   = w_issue_ready;
    assign pending_count = r_count;
    assign wb_orphan     = r_orphan;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb
// Purpose  : Directed self-checking bench for regfile_wb. Inputs change on
//            the falling edge; combinational outputs are checked 1 ns later,
//            registered outputs on the falling edge after the active edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb;

    logic        clk;
    logic        reset;
    logic [4:0]  rs_addr, rt_addr;
    logic [31:0] rs_data, rt_data;
    logic        rs_busy, rt_busy;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic [5:0]  pending_count;
    logic        wb_orphan;

    int n_total = 0;
    int n_bad   = 0;

    regfile_wb #(.W(32), .NREG(32)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .rs_busy      (rs_busy),
        .rt_busy      (rt_busy),
        .issue_valid  (issue_valid),
        .issue_dest   (issue_dest),
        .issue_ready  (issue_ready),
        .wb_valid     (wb_valid),
        .wb_dest      (wb_dest),
        .wb_data      (wb_data),
        .pending_count(pending_count),
        .wb_orphan    (wb_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one active edge and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_dest  = '0;
        wb_valid    = 1'b0;
        wb_dest     = '0;
        wb_data     = '0;
    endtask

    initial begin
        reset   = 1'b1;
        rs_addr = '0;
        rt_addr = '0;
        idle();
        @(negedge clk);
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a);
            rt_addr = 5'(31 - a);
            #1;
            check("rst_rs_data", rs_data, 32'h0);
            check("rst_rt_data", rt_data, 32'h0);
            check("rst_rs_busy", {31'b0, rs_busy}, 32'h0);
        end
        issue_dest = 5'd5;
        #1;
        check("rst_issue_ready", {31'b0, issue_ready}, 32'h1);
        check("rst_pending", {26'b0, pending_count}, 32'd0);
        check("rst_orphan", {31'b0, wb_orphan}, 32'h0);

        // Issue 5, then attempt re-issue (WAW stall)
        @(negedge clk);
        issue_valid = 1'b1;
        issue_dest  = 5'd5;
        #1;
        check("iss5_ready", {31'b0, issue_ready}, 32'h1);
        tick();
        rs_addr = 5'd5;
        rt_addr = 5'd5;
        #1;
        check("reiss5_ready", {31'b0, issue_ready}, 32'h0);
        check("reiss5_rs_busy", {31'b0, rs_busy}, 32'h1);
        check("reiss5_rt_busy", {31'b0, rt_busy}, 32'h1);
        check("reiss5_pending", {26'b0, pending_count}, 32'd1);
        tick();
        check("stall5_pending", {26'b0, pending_count}, 32'd1);

        // Retire 5 with bypass
        idle();
        wb_valid = 1'b1;
        wb_dest  = 5'd5;
        wb_data  = 32'hDEADBEEF;
        #1;
        check("wb5_byp_rs", rs_data, 32'hDEADBEEF);
        check("wb5_byp_rt", rt_data, 32'hDEADBEEF);
        check("wb5_byp_busy", {31'b0, rs_busy}, 32'h0);
        tick();
        idle();
        #1;
        check("wb5_pending", {26'b0, pending_count}, 32'd0);
        check("wb5_array", rs_data, 32'hDEADBEEF);
        check("wb5_busy", {31'b0, rs_busy}, 32'h0);
        check("wb5_orphan", {31'b0, wb_orphan}, 32'h0);

        // Issue 7, then issue + write-back 7 in the same cycle
        issue_valid = 1'b1;
        issue_dest  = 5'd7;
        tick();
        check("iss7_pending", {26'b0, pending_count}, 32'd1);
        wb_valid = 1'b1;
        wb_dest  = 5'd7;
        wb_data  = 32'h00000077;
        #1;
        check("same7_ready", {31'b0, issue_ready}, 32'h1);
        tick();
        idle();
        rs_addr    = 5'd7;
        issue_dest = 5'd7;
        #1;
        check("same7_data", rs_data, 32'h00000077);
        check("same7_busy", {31'b0, rs_busy}, 32'h1);
        check("same7_pending", {26'b0, pending_count}, 32'd1);
        check("same7_ready_after", {31'b0, issue_ready}, 32'h0);
        check("same7_orphan", {31'b0, wb_orphan}, 32'h0);

        // Retire 7 normally
        wb_valid = 1'b1;
        wb_dest  = 5'd7;
        wb_data  = 32'h00000700;
        tick();
        idle();
        #1;
        check("wb7_data", rs_data, 32'h00000700);
        check("wb7_pending", {26'b0, pending_count}, 32'd0);
        check("wb7_orphan", {31'b0, wb_orphan}, 32'h0);

        // Register 0 discards writes and issues
        rs_addr  = 5'd0;
        wb_valid = 1'b1;
        wb_dest  = 5'd0;
        wb_data  = 32'h00001234;
        #1;
        check("wb0_byp", rs_data, 32'h0);
        tick();
        idle();
        issue_valid = 1'b1;
        issue_dest  = 5'd0;
        #1;
        check("wb0_orphan", {31'b0, wb_orphan}, 32'h0);
        check("wb0_array", rs_data, 32'h0);
        check("iss0_ready", {31'b0, issue_ready}, 32'h1);
        tick();
        idle();
        #1;
        check("iss0_pending", {26'b0, pending_count}, 32'd0);
        check("iss0_busy", {31'b0, rs_busy}, 32'h0);

        // Orphan write-back to non-busy 9
        wb_valid = 1'b1;
        wb_dest  = 5'd9;
        wb_data  = 32'h00000099;
        tick();
        idle();
        rs_addr = 5'd9;
        #1;
        check("orph9_pulse", {31'b0, wb_orphan}, 32'h1);
        check("orph9_data", rs_data, 32'h00000099);
        check("orph9_pending", {26'b0, pending_count}, 32'd0);
        tick();
        check("orph9_pulse_end", {31'b0, wb_orphan}, 32'h0);

        // Fill the scoreboard
        for (int d = 1; d < 32; d++) begin
            issue_valid = 1'b1;
            issue_dest  = 5'(d);
            tick();
        end
        idle();
        rt_addr    = 5'd3;
        issue_dest = 5'd12;
        #1;
        check("full_pending", {26'b0, pending_count}, 32'd31);
        check("full_rt_busy", {31'b0, rt_busy}, 32'h1);
        check("full_ready", {31'b0, issue_ready}, 32'h0);

        // Reset with concurrent write-back to 3
        reset    = 1'b1;
        wb_valid = 1'b1;
        wb_dest  = 5'd3;
        wb_data  = 32'h0000AAAA;
        tick();
        reset = 1'b0;
        idle();
        rs_addr    = 5'd5;
        issue_dest = 5'd12;
        #1;
        check("rst2_pending", {26'b0, pending_count}, 32'd0);
        check("rst2_rt_data", rt_data, 32'h0);
        check("rst2_rt_busy", {31'b0, rt_busy}, 32'h0);
        check("rst2_rs_data", rs_data, 32'h0);
        check("rst2_ready", {31'b0, issue_ready}, 32'h1);
        check("rst2_orphan", {31'b0, wb_orphan}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
